// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the direct-mapped write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } cache_state_t;

  // Widest word address the helpers accept; callers zero-extend into it.
  localparam int unsigned ADDR_MAX_W = 32;

  // Line index: the low index_w bits of the word address.
  function automatic logic [ADDR_MAX_W-1:0] get_index(input logic [ADDR_MAX_W-1:0] addr,
                                                      input int unsigned           index_w);
    logic [ADDR_MAX_W-1:0] mask;
    mask = (32'd1 << index_w) - 32'd1;
    return addr & mask;
  endfunction

  // Tag: everything above the index bits.
  function automatic logic [ADDR_MAX_W-1:0] get_tag(input logic [ADDR_MAX_W-1:0] addr,
                                                    input int unsigned           index_w);
    return addr >> index_w;
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Valid/tag/data storage for the cache: combinational lookup, one write port,
// single-cycle invalidate of every line, async clear on reset.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TAG_W   = 6,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               gen_reset,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               lookup_hit,
  output logic [DATA_W-1:0]  lookup_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               invalidate_all
);

  localparam int unsigned LINES = 2 ** INDEX_W;

  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [DATA_W-1:0] data_r [LINES];

  // Lookup is purely combinational so a read hit can be answered the next cycle.
  assign lookup_hit  = valid_r[lookup_index] && (tag_r[lookup_index] == lookup_tag);
  assign lookup_data = data_r[lookup_index];

  // Line storage: invalidate only touches valid bits; tags and data are kept.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      valid_r <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_r[i]  <= '0;
        data_r[i] <= '0;
      end
    end else if (invalidate_all) begin
      valid_r <= '0;
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
      tag_r[wr_index]   <= wr_tag;
      data_r[wr_index]  <= wr_data;
    end
  end

endmodule

// File: rtl/cache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate cache, one word per line.
// Holds the request FSM, captured memory request, and read hit/miss counters.
module cache_dm_wt
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int unsigned    TAG_W   = ADDR_W - INDEX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  cache_state_t        state_r;
  cache_state_t        state_next_s;

  logic                cpu_ready_s;
  logic                accept_s;
  logic                rd_hit_s;
  logic                rd_miss_s;
  logic                wr_acc_s;
  logic                mem_done_s;
  logic                fill_ack_s;

  logic [INDEX_W-1:0]  cpu_index_s;
  logic [TAG_W-1:0]    cpu_tag_s;
  logic [INDEX_W-1:0]  fill_index_s;
  logic [TAG_W-1:0]    fill_tag_s;

  logic                lookup_hit_s;
  logic [DATA_W-1:0]   lookup_data_s;
  logic                store_wr_en_s;
  logic [INDEX_W-1:0]  store_wr_index_s;
  logic [TAG_W-1:0]    store_wr_tag_s;
  logic [DATA_W-1:0]   store_wr_data_s;
  logic                invalidate_s;

  logic                cpu_done_r;
  logic [DATA_W-1:0]   cpu_rdata_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [CNT_W-1:0]    hit_cnt_r;
  logic [CNT_W-1:0]    miss_cnt_r;

  // Address split for the incoming request and for the outstanding fill.
  assign cpu_index_s  = INDEX_W'(get_index(ADDR_MAX_W'(cpu_addr), INDEX_W));
  assign cpu_tag_s    = TAG_W'(get_tag(ADDR_MAX_W'(cpu_addr), INDEX_W));
  assign fill_index_s = INDEX_W'(get_index(ADDR_MAX_W'(mem_addr_r), INDEX_W));
  assign fill_tag_s   = TAG_W'(get_tag(ADDR_MAX_W'(mem_addr_r), INDEX_W));

  // Requests are only taken in IDLE, and a flush in IDLE blocks acceptance.
  assign cpu_ready_s = (state_r == IDLE) && !flush;
  assign accept_s    = cpu_req && cpu_ready_s;
  assign rd_hit_s    = accept_s && !cpu_we && lookup_hit_s;
  assign rd_miss_s   = accept_s && !cpu_we && !lookup_hit_s;
  assign wr_acc_s    = accept_s && cpu_we;
  assign fill_ack_s  = (state_r == FILL) && mem_ack;
  assign invalidate_s = (state_r == IDLE) && flush;

  cache_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_line_store (
    .clk            (clk),
    .gen_reset      (gen_reset),
    .lookup_index   (cpu_index_s),
    .lookup_tag     (cpu_tag_s),
    .lookup_hit     (lookup_hit_s),
    .lookup_data    (lookup_data_s),
    .wr_en          (store_wr_en_s),
    .wr_index       (store_wr_index_s),
    .wr_tag         (store_wr_tag_s),
    .wr_data        (store_wr_data_s),
    .invalidate_all (invalidate_s)
  );

  // State register.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; mem_done_s marks the ack that completes FILL or WRITE.
  always_comb begin
    state_next_s = state_r;
    mem_done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_miss_s) begin
          state_next_s = FILL;
        end else if (wr_acc_s) begin
          state_next_s = WRITE;
        end else begin
          state_next_s = IDLE;
        end
      end
      FILL, WRITE: begin
        if (mem_ack) begin
          state_next_s = IDLE;
          mem_done_s   = 1'b1;
        end else begin
          state_next_s = state_r;
          mem_done_s   = 1'b0;
        end
      end
      default: begin
        state_next_s = IDLE;
        mem_done_s   = 1'b0;
      end
    endcase
  end

  // Line write select: a completed fill installs the line; a write hit updates it in place.
  always_comb begin
    store_wr_en_s    = 1'b0;
    store_wr_index_s = cpu_index_s;
    store_wr_tag_s   = cpu_tag_s;
    store_wr_data_s  = cpu_wdata;
    if (fill_ack_s) begin
      store_wr_en_s    = 1'b1;
      store_wr_index_s = fill_index_s;
      store_wr_tag_s   = fill_tag_s;
      store_wr_data_s  = mem_rdata;
    end else if (wr_acc_s && lookup_hit_s) begin
      store_wr_en_s    = 1'b1;
      store_wr_index_s = cpu_index_s;
      store_wr_tag_s   = cpu_tag_s;
      store_wr_data_s  = cpu_wdata;
    end else begin
      store_wr_en_s    = 1'b0;
      store_wr_index_s = cpu_index_s;
      store_wr_tag_s   = cpu_tag_s;
      store_wr_data_s  = cpu_wdata;
    end
  end

  // CPU response: done pulses once per request; read data holds across writes.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      cpu_done_r  <= 1'b0;
      cpu_rdata_r <= '0;
    end else begin
      cpu_done_r <= rd_hit_s || mem_done_s;
      if (rd_hit_s) begin
        cpu_rdata_r <= lookup_data_s;
      end else if (fill_ack_s) begin
        cpu_rdata_r <= mem_rdata;
      end
    end
  end

  // Memory request: captured at acceptance, held stable until the ack.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else if (rd_miss_s || wr_acc_s) begin
      mem_req_r  <= 1'b1;
      mem_we_r   <= cpu_we;
      mem_addr_r <= cpu_addr;
      if (cpu_we) begin
        mem_wdata_r <= cpu_wdata;
      end
    end else if (mem_done_s) begin
      mem_req_r <= 1'b0;
      mem_we_r  <= 1'b0;
    end
  end

  // Saturating read hit/miss counters, bumped at acceptance.
  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      hit_cnt_r  <= '0;
      miss_cnt_r <= '0;
    end else begin
      if (rd_hit_s && (hit_cnt_r != CNT_MAX)) begin
        hit_cnt_r <= hit_cnt_r + CNT_ONE;
      end
      if (rd_miss_s && (miss_cnt_r != CNT_MAX)) begin
        miss_cnt_r <= miss_cnt_r + CNT_ONE;
      end
    end
  end

  assign cpu_ready = cpu_ready_s;
  assign cpu_done  = cpu_done_r;
  assign cpu_rdata = cpu_rdata_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign hit_cnt   = hit_cnt_r;
  assign miss_cnt  = miss_cnt_r;

endmodule

// File: tb/tb_cache_dm_wt.sv
// Directed, table-driven bench for cache_dm_wt with a latency-programmable RAM model.
module tb_cache_dm_wt;

  logic        clk;
  logic        gen_reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [9:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ready;
  logic        cpu_done;
  logic [31:0] cpu_rdata;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int n_total;
  int n_pass;
  int mem_lat;
  int mem_cnt;
  logic mem_init;
  logic [31:0] mem_arr [1024];

  cache_dm_wt dut (
    .clk       (clk),
    .gen_reset (gen_reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .flush     (flush),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: acks on the mem_lat-th cycle of a request, data valid with the ack.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem_arr[i] = 32'hC0DE0000 | 32'(i);
      mem_arr[10'h005] = 32'hDEADBEEF;
      mem_arr[10'h015] = 32'h11110015;
      mem_arr[10'h0AA] = 32'hAAAA00AA;
      mem_init = 1'b1;
    end
    if (mem_req && !mem_ack) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_arr[mem_addr];
        if (mem_we) mem_arr[mem_addr] = mem_wdata;
      end
    end else begin
      mem_ack   = 1'b0;
      mem_cnt   = 0;
      mem_rdata = 32'h0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One CPU request: present for one edge, then wait (bounded) for cpu_done.
  task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output int mem_cyc, output logic done_seen,
                        output logic [9:0] m_addr, output logic m_we, output logic [31:0] m_wdata);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    rd = 32'h0; mem_cyc = 0; done_seen = 1'b0;
    m_addr = 10'h0; m_we = 1'b0; m_wdata = 32'h0;
    for (int i = 0; i < 40 && !done_seen; i++) begin
      @(negedge clk);
      if (mem_req) begin
        if (mem_cyc == 0) begin
          m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
        end
        mem_cyc++;
      end
      if (cpu_done) begin
        done_seen = 1'b1;
        rd = cpu_rdata;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] exp_rdata;
    int          exp_mem;
    logic [31:0] exp_hit;
    logic [31:0] exp_miss;
  } vec_t;

  vec_t vecs [10];

  initial begin
    logic [31:0] rd;
    int          mcyc;
    logic        dn;
    logic [9:0]  maddr;
    logic        mwe;
    logic [31:0] mwd;
    logic        seen_done;

    n_total = 0; n_pass = 0; mem_lat = 3; mem_cnt = 0; mem_init = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'h0;
    gen_reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 10'h0;
    cpu_wdata = 32'h0; flush = 1'b0;

    vecs[0] = '{1'b0, 10'h005, 32'h0,        3, 32'hDEADBEEF, 3, 32'd0, 32'd1};
    vecs[1] = '{1'b0, 10'h005, 32'h0,        3, 32'hDEADBEEF, 0, 32'd1, 32'd1};
    vecs[2] = '{1'b0, 10'h015, 32'h0,        2, 32'h11110015, 2, 32'd1, 32'd2};
    vecs[3] = '{1'b0, 10'h005, 32'h0,        1, 32'hDEADBEEF, 1, 32'd1, 32'd3};
    vecs[4] = '{1'b1, 10'h005, 32'h12345678, 2, 32'hDEADBEEF, 2, 32'd1, 32'd3};
    vecs[5] = '{1'b0, 10'h005, 32'h0,        2, 32'h12345678, 0, 32'd2, 32'd3};
    vecs[6] = '{1'b1, 10'h0AA, 32'h0BADCAFE, 1, 32'h12345678, 1, 32'd2, 32'd3};
    vecs[7] = '{1'b0, 10'h0AA, 32'h0,        2, 32'h0BADCAFE, 2, 32'd2, 32'd4};
    vecs[8] = '{1'b0, 10'h0AA, 32'h0,        2, 32'h0BADCAFE, 0, 32'd3, 32'd4};
    vecs[9] = '{1'b0, 10'h015, 32'h0,        3, 32'h11110015, 3, 32'd3, 32'd5};

    // Reset values.
    repeat (2) @(negedge clk);
    gen_reset = 1'b0;
    #1;
    check("rst_ready",     32'(cpu_ready), 32'd1);
    check("rst_done",      32'(cpu_done),  32'd0);
    check("rst_rdata",     cpu_rdata,      32'h0);
    check("rst_mem_req",   32'(mem_req),   32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'h0);
    check("rst_mem_wdata", mem_wdata,      32'h0);
    check("rst_hit_cnt",   32'(hit_cnt),   32'd0);
    check("rst_miss_cnt",  32'(miss_cnt),  32'd0);

    // Table: single requests with varied RAM latency.
    for (int i = 0; i < 10; i++) begin
      mem_lat = vecs[i].lat;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, mcyc, dn, maddr, mwe, mwd);
      check($sformatf("v%0d_done", i),     32'(dn),       32'd1);
      check($sformatf("v%0d_rdata", i),    rd,            vecs[i].exp_rdata);
      check($sformatf("v%0d_mem_cyc", i),  32'(mcyc),     32'(vecs[i].exp_mem));
      check($sformatf("v%0d_hit_cnt", i),  32'(hit_cnt),  vecs[i].exp_hit);
      check($sformatf("v%0d_miss_cnt", i), 32'(miss_cnt), vecs[i].exp_miss);
      if (vecs[i].exp_mem > 0) begin
        check($sformatf("v%0d_mem_addr", i), 32'(maddr), 32'(vecs[i].addr));
        check($sformatf("v%0d_mem_we", i),   32'(mwe),   32'(vecs[i].we));
        if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), mwd, vecs[i].wdata);
      end
      @(negedge clk);
      check($sformatf("v%0d_single_pulse", i), 32'(cpu_done), 32'd0);
    end

    // Refill 0x005 (line 5 holds 0x015), then four back-to-back hits.
    mem_lat = 1;
    do_req(1'b0, 10'h005, 32'h0, rd, mcyc, dn, maddr, mwe, mwd);
    check("refill_rdata", rd, 32'h12345678);
    check("refill_miss",  32'(miss_cnt), 32'd6);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    #1;
    check("b2b_ready_first", 32'(cpu_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("b2b%0d_done", i),    32'(cpu_done),  32'd1);
      check($sformatf("b2b%0d_rdata", i),   cpu_rdata,      32'h12345678);
      check($sformatf("b2b%0d_mem_req", i), 32'(mem_req),   32'd0);
      check($sformatf("b2b%0d_ready", i),   32'(cpu_ready), 32'd1);
      if (i == 3) cpu_req = 1'b0;
    end
    check("b2b_hit_cnt", 32'(hit_cnt), 32'd7);

    // Flush together with a request: not accepted, line invalidated.
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
    #1;
    check("flush_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    check("flush_no_done",    32'(cpu_done), 32'd0);
    check("flush_no_mem_req", 32'(mem_req),  32'd0);
    mem_lat = 2;
    do_req(1'b0, 10'h005, 32'h0, rd, mcyc, dn, maddr, mwe, mwd);
    check("post_flush_mem_cyc", 32'(mcyc),     32'd2);
    check("post_flush_rdata",   rd,            32'h12345678);
    check("post_flush_miss",    32'(miss_cnt), 32'd7);
    check("post_flush_hit",     32'(hit_cnt),  32'd7);

    // Reset in the middle of a fill.
    mem_lat = 6;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h033;
    @(negedge clk);
    cpu_req = 1'b0;
    check("midfill_mem_req", 32'(mem_req), 32'd1);
    #2;
    gen_reset = 1'b1;
    #1;
    check("midfill_async_drop", 32'(mem_req), 32'd0);
    @(negedge clk);
    gen_reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpu_done || mem_req) seen_done = 1'b1;
    end
    check("midfill_no_done", 32'(seen_done), 32'd0);
    check("midfill_hit_cnt", 32'(hit_cnt),   32'd0);
    check("midfill_miss_cnt", 32'(miss_cnt), 32'd0);
    check("midfill_ready",   32'(cpu_ready), 32'd1);
    check("midfill_rdata",   cpu_rdata,      32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
